shift_exec_stage: RTL and testbench

Execute-stage wrapper that feeds the combinational `shift` unit and registers its result. It buffers shift operations in a small operand FIFO and drives the FIFO head onto the shifter's `a`/`shift_count`/`dir` inputs. It captures the shifter's `y` together with zero and carry flags into an output register, with valid/ready handshakes on both sides. It sits between operand read/decode and the writeback/flags stage of the ASIP datapath.

---
 rtl/shift_exec_stage.sv | 193 +++++++++++++++++++
 tb/tb_shift_exec_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_exec_stage.sv
// -----------------------------------------------------------------------------
// shift_exec_stage
//
// Execute-stage wrapper around the external combinational `shift` unit.
// Shift operations from operand read/decode are buffered in a small operand
// FIFO. The FIFO head is driven onto the shifter inputs. The shifter result is
// captured, together with zero and carry flags, into an output register that
// feeds the writeback/flags stage.
//
// Optional feature macro: SHIFT_CARRY_EN
//   defined   : out_carry is the last bit shifted out of the head operand
//   undefined : carry logic is omitted and out_carry is tied to 0
//
// Parameters
//   bus        data width (must match the attached shift instance)
//   bus_shift  shift-count width, $clog2(bus)
//   DEPTH      operand FIFO entries, power of two, >= 2
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream offers an operation
//   in_ready   FIFO not full (registered state only)
//   in_a       operand
//   in_count   shift amount
//   in_dir     1 = logical right, 0 = logical left
//   sh_a       to shifter a           (0 when FIFO empty)
//   sh_count   to shifter shift_count (0 when FIFO empty)
//   sh_dir     to shifter dir         (0 when FIFO empty)
//   sh_y       from shifter y
//   out_valid  result register holds a result
//   out_ready  downstream accepts
//   out_y      registered shift result
//   out_zero   out_y == 0
//   out_carry  last bit shifted out
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. A valid source keeps its payload stable until the transfer. On the
// output side, out_y/out_zero/out_carry hold while out_valid && !out_ready.
// -----------------------------------------------------------------------------
module shift_exec_stage #(
  parameter int bus       = 4,
  parameter int bus_shift = $clog2(bus),
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [bus-1:0]       in_a,
  input  logic [bus_shift-1:0] in_count,
  input  logic                 in_dir,
  output logic [bus-1:0]       sh_a,
  output logic [bus_shift-1:0] sh_count,
  output logic                 sh_dir,
  input  logic [bus-1:0]       sh_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [bus-1:0]       out_y,
  output logic                 out_zero,
  output logic                 out_carry
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Operand FIFO storage. Entries are only observed through the head mux,
  // which forces zeros while empty, so the storage itself needs no reset.
  logic [bus-1:0]       r_mem_a   [DEPTH];
  logic [bus_shift-1:0] r_mem_cnt [DEPTH];
  logic                 r_mem_dir [DEPTH];

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // index with differing wrap bit means full.
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;

  logic          r_valid;
  logic [bus-1:0] r_y;
  logic          r_zero;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_load;
  logic [AW-1:0] w_widx;
  logic [AW-1:0] w_ridx;

  assign w_widx  = r_wptr[AW-1:0];
  assign w_ridx  = r_rptr[AW-1:0];
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW-1] != r_rptr[PW-1]) && (w_widx == w_ridx);

  // No bypass: a pop in the same cycle does not open the input.
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;
  assign w_load   = !w_empty && (!r_valid || out_ready);

  // ---------------------------------------------------------------------------
  // FIFO pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_load) begin
        r_rptr <= r_rptr + PW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage write
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[w_widx]   <= in_a;
      r_mem_cnt[w_widx] <= in_count;
      r_mem_dir[w_widx] <= in_dir;
    end
  end

  // ---------------------------------------------------------------------------
  // Head drive to the shifter
  // ---------------------------------------------------------------------------
  always_comb begin
    sh_a     = '0;
    sh_count = '0;
    sh_dir   = 1'b0;
    if (!w_empty) begin
      sh_a     = r_mem_a[w_ridx];
      sh_count = r_mem_cnt[w_ridx];
      sh_dir   = r_mem_dir[w_ridx];
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_y     <= '0;
      r_zero  <= 1'b0;
    end else begin
      if (w_load) begin
        r_valid <= 1'b1;
        r_y     <= sh_y;
        r_zero  <= (sh_y == '0);
      end else if (r_valid && out_ready) begin
        // Drained: data and flags keep their last value.
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_y     = r_y;
  assign out_zero  = r_zero;

`ifdef SHIFT_CARRY_EN
  // Last bit shifted out of the head operand for count n:
  //   n = 0 -> 0, left -> a[bus-n], right -> a[n-1]
  logic w_carry;
  logic r_carry;

  always_comb begin
    w_carry = 1'b0;
    for (int i = 1; i < bus; i++) begin
      if (sh_count == bus_shift'(i)) begin
        w_carry = sh_dir ? sh_a[i-1] : sh_a[bus-i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
    end else if (w_load) begin
      r_carry <= w_carry;
    end
  end

  assign out_carry = r_carry;
`else
  assign out_carry = 1'b0;
`endif

endmodule

// File: tb/tb_shift_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_shift_exec_stage
//
// Directed bench for shift_exec_stage. A behavioural logical shifter stands in
// for the external `shift` unit. Expected values are hand-computed constants;
// result data under backpressure are queued in exp_q in issue order.
// -----------------------------------------------------------------------------
module tb_shift_exec_stage;

  localparam int BUS = 4;
  localparam int BSH = 2;

`ifdef SHIFT_CARRY_EN
  localparam logic CEN = 1'b1;
`else
  localparam logic CEN = 1'b0;
`endif

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [BUS-1:0] in_a;
  logic [BSH-1:0] in_count;
  logic           in_dir;
  logic [BUS-1:0] sh_a;
  logic [BSH-1:0] sh_count;
  logic           sh_dir;
  logic [BUS-1:0] sh_y;
  logic           out_valid;
  logic           out_ready;
  logic [BUS-1:0] out_y;
  logic           out_zero;
  logic           out_carry;

  int n_vec;
  int n_err;
  logic [BUS-1:0] exp_q [$];
  logic [BUS-1:0] held_y;

  shift_exec_stage #(.bus(BUS), .bus_shift(BSH), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_count  (in_count),
    .in_dir    (in_dir),
    .sh_a      (sh_a),
    .sh_count  (sh_count),
    .sh_dir    (sh_dir),
    .sh_y      (sh_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_zero  (out_zero),
    .out_carry (out_carry)
  );

  // Stand-in for the external combinational shifter.
  assign sh_y = sh_dir ? (sh_a >> sh_count) : (sh_a << sh_count);

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Driver / check tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [BUS-1:0] a,
                       input logic [BSH-1:0] c, input logic d);
    in_valid = v;
    in_a     = a;
    in_count = c;
    in_dir   = d;
  endtask

  // Single operation through an idle stage with out_ready = 1.
  task automatic one_op(input string tag, input logic [BUS-1:0] a,
                        input logic [BSH-1:0] c, input logic d,
                        input logic [BUS-1:0] y, input logic z, input logic cy);
    drive(1'b1, a, c, d);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    chk({tag, "_sh_a"}, 8'(sh_a), 8'(a));
    tick();
    chk({tag, "_valid"}, 8'(out_valid), 8'h1);
    chk({tag, "_y"},     8'(out_y),     8'(y));
    chk({tag, "_zero"},  8'(out_zero),  8'(z));
    chk({tag, "_carry"}, 8'(out_carry), 8'(cy & CEN));
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0);

    // Reset asserted mid-cycle, before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready",  8'(in_ready),  8'h1);
    chk("rst_out_valid", 8'(out_valid), 8'h0);
    chk("rst_out_y",     8'(out_y),     8'h0);
    chk("rst_out_zero",  8'(out_zero),  8'h0);
    chk("rst_out_carry", 8'(out_carry), 8'h0);
    chk("rst_sh_a",      8'(sh_a),      8'h0);
    chk("rst_sh_count",  8'(sh_count),  8'h0);
    chk("rst_sh_dir",    8'(sh_dir),    8'h0);
    tick();
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_out_valid", 8'(out_valid), 8'h0);
    end

    // Single operations.
    one_op("lsl2",  4'b0001, 2'd2, 1'b0, 4'b0100, 1'b0, 1'b0);
    one_op("lsl0",  4'b1010, 2'd0, 1'b0, 4'b1010, 1'b0, 1'b0);
    one_op("lsr1",  4'b1011, 2'd1, 1'b1, 4'b0101, 1'b0, 1'b1);
    one_op("lsr3",  4'b1000, 2'd3, 1'b1, 4'b0001, 1'b0, 1'b0);
    one_op("zero",  4'b0110, 2'd3, 1'b0, 4'b0000, 1'b1, 1'b1);
    one_op("lsl1",  4'b1101, 2'd1, 1'b0, 4'b1010, 1'b0, 1'b1);
    tick();
    chk("drain_valid", 8'(out_valid), 8'h0);
    chk("drain_hold_y", 8'(out_y), 8'b1010);
    chk("empty_sh_a", 8'(sh_a), 8'h0);

    // Backpressure: offer 4 operations with out_ready = 0.
    out_ready = 1'b0;
    exp_q.push_back(4'b0110);  // 0011 << 1
    exp_q.push_back(4'b0010);  // 1001 >> 2
    exp_q.push_back(4'b0011);  // 0111 >> 1
    exp_q.push_back(4'b1000);  // 1111 << 3
    drive(1'b1, 4'b0011, 2'd1, 1'b0);
    chk("bp_rdy0", 8'(in_ready), 8'h1);
    tick();
    drive(1'b1, 4'b1001, 2'd2, 1'b1);
    chk("bp_rdy1", 8'(in_ready), 8'h1);
    tick();
    drive(1'b1, 4'b0111, 2'd1, 1'b1);
    chk("bp_rdy2", 8'(in_ready), 8'h1);
    tick();
    drive(1'b1, 4'b1111, 2'd3, 1'b0);
    chk("bp_rdy3_full", 8'(in_ready), 8'h0);
    chk("bp_valid", 8'(out_valid), 8'h1);
    held_y = exp_q.pop_front();
    chk("bp_y0", 8'(out_y), 8'(held_y));
    chk("bp_carry0", 8'(out_carry), 8'h0);
    tick();
    chk("bp_hold_y", 8'(out_y), 8'(held_y));
    chk("bp_hold_full", 8'(in_ready), 8'h0);
    out_ready = 1'b1;
    // in_ready must not react combinationally to out_ready.
    #1 chk("bp_rdy_no_comb", 8'(in_ready), 8'h0);
    tick();
    held_y = exp_q.pop_front();
    chk("bp_y1", 8'(out_y), 8'(held_y));
    chk("bp_carry1", 8'(out_carry), 8'h0);
    chk("bp_rdy_rise", 8'(in_ready), 8'h1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    held_y = exp_q.pop_front();
    chk("bp_y2", 8'(out_y), 8'(held_y));
    chk("bp_carry2", 8'(out_carry), 8'(CEN));
    tick();
    held_y = exp_q.pop_front();
    chk("bp_y3", 8'(out_y), 8'(held_y));
    chk("bp_valid3", 8'(out_valid), 8'h1);
    chk("bp_carry3", 8'(out_carry), 8'(CEN));
    tick();
    chk("bp_done", 8'(out_valid), 8'h0);

    // Reset mid-traffic with FIFO full and a held result.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'(i + 1), 2'd1, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0);
    chk("mr_full", 8'(in_ready), 8'h0);
    chk("mr_valid", 8'(out_valid), 8'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_rst_valid", 8'(out_valid), 8'h0);
    chk("mr_rst_rdy", 8'(in_ready), 8'h1);
    chk("mr_rst_y", 8'(out_y), 8'h0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_no_old", 8'(out_valid), 8'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
